regfile_mp: RTL and testbench

//  Parametrised multi-port register file for the pipelined datapath: NUM_RD read ports,
//  2 write ports, optional write-to-read bypass, hardwired zero register (XZR).
//  Per-register pending scoreboard: issue reserves a destination, writeback clears it,
//  and each read port reports whether its operand is ready. Sits between decode/issue and writeback.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_mp_if.sv | 30 +++
 rtl/regfile_scoreboard.sv | 55 +++++
 rtl/regfile_mp.sv | 83 ++++++++
 tb/tb_regfile_mp.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and typedefs for the multi-port register file slice.
package regfile_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int ADDR_W_DEF = 5;
    localparam int XZR_IDX    = 31;
    localparam int NUM_WR     = 2;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
    typedef logic [DATA_W_DEF-1:0] reg_data_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Read, write and reservation bus between issue/writeback and the register file.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2
);

    logic [NUM_RD*ADDR_W-1:0] readReg;
    logic [NUM_RD*DATA_W-1:0] readData;
    logic [NUM_RD-1:0]        readReady;
    logic [NUM_WR*ADDR_W-1:0] writeReg;
    logic [NUM_WR*DATA_W-1:0] writeData;
    logic [NUM_WR-1:0]        regWriteEnable;
    logic                     reserveEn;
    logic [ADDR_W-1:0]        reserveReg;
    logic                     anyPending;

    modport master (
        output readReg, writeReg, writeData, regWriteEnable, reserveEn, reserveReg,
        input  readData, readReady, anyPending
    );

    modport slave (
        input  readReg, writeReg, writeData, regWriteEnable, reserveEn, reserveReg,
        output readData, readReady, anyPending
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: issue sets, writeback clears, a same-cycle set beats the clear.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = XZR_IDX
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     reserveEn,
    input  logic [ADDR_W-1:0]        reserveReg,
    input  logic [NUM_WR-1:0]        writeEn,
    input  logic [NUM_WR*ADDR_W-1:0] writeReg,
    output logic [(2**ADDR_W)-1:0]   pending,
    output logic                     anyPending
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [(2**ADDR_W)-1:0] pend_r;
    logic [(2**ADDR_W)-1:0] pend_next_s;
    logic                   any_pend_r;

    // Next pending state: clears from writeback first so a new reservation overrides them.
    always_comb begin
        pend_next_s = pend_r;
        for (int w = 0; w < NUM_WR; w++) begin
            if (writeEn[w]) begin
                pend_next_s[writeReg[w*ADDR_W +: ADDR_W]] = 1'b0;
            end else begin
                pend_next_s = pend_next_s;
            end
        end
        if (reserveEn && (reserveReg != ZERO_ADDR)) begin
            pend_next_s[reserveReg] = 1'b1;
        end else begin
            pend_next_s = pend_next_s;
        end
    end

    // Pending bits and the registered drain flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_r     <= '0;
            any_pend_r <= 1'b0;
        end else begin
            pend_r     <= pend_next_s;
            any_pend_r <= |pend_next_s;
        end
    end

    assign pending    = pend_r;
    assign anyPending = any_pend_r;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with two write ports, optional write bypass and a hardwired zero register.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = XZR_IDX,
    parameter int BYPASS   = 1
) (
    input logic         clk,
    input logic         reset,
    regfile_mp_if.slave bus
);

    localparam int                DEPTH     = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DEPTH-1:0]  pending_s;
    logic              any_pend_s;
    logic [ADDR_W-1:0] rd_addr_s [NUM_RD];
    logic [NUM_RD-1:0] byp_hit_s;

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .reserveEn  (bus.reserveEn),
        .reserveReg (bus.reserveReg),
        .writeEn    (bus.regWriteEnable),
        .writeReg   (bus.writeReg),
        .pending    (pending_s),
        .anyPending (any_pend_s)
    );

    // Storage: port 1 is applied after port 0 so it wins on an address collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (bus.regWriteEnable[w] && (bus.writeReg[w*ADDR_W +: ADDR_W] != ZERO_ADDR)) begin
                    mem_r[bus.writeReg[w*ADDR_W +: ADDR_W]] <= bus.writeData[w*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Read mux per port: bypass compare, then stored value, then the zero-register override.
    always_comb begin
        bus.readData  = '0;
        bus.readReady = '0;
        byp_hit_s     = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            rd_addr_s[p] = bus.readReg[p*ADDR_W +: ADDR_W];
            bus.readData[p*DATA_W +: DATA_W] = mem_r[rd_addr_s[p]];
            for (int w = 0; w < NUM_WR; w++) begin
                if ((BYPASS != 0) && bus.regWriteEnable[w] &&
                    (bus.writeReg[w*ADDR_W +: ADDR_W] == rd_addr_s[p])) begin
                    bus.readData[p*DATA_W +: DATA_W] = bus.writeData[w*DATA_W +: DATA_W];
                    byp_hit_s[p] = 1'b1;
                end else begin
                    byp_hit_s[p] = byp_hit_s[p];
                end
            end
            bus.readReady[p] = byp_hit_s[p] | ~pending_s[rd_addr_s[p]];
            if (rd_addr_s[p] == ZERO_ADDR) begin
                bus.readData[p*DATA_W +: DATA_W] = '0;
                bus.readReady[p] = 1'b1;
            end else begin
                bus.readReady[p] = bus.readReady[p];
            end
        end
    end

    assign bus.anyPending = any_pend_s;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: read expectations queued at stimulus time, popped when outputs settle.
module tb_regfile_mp;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(64), .ADDR_W(5), .NUM_RD(2)) bus ();
    regfile_mp_if #(.DATA_W(64), .ADDR_W(5), .NUM_RD(2)) bus_nb ();

    regfile_mp #(.DATA_W(64), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(31), .BYPASS(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    regfile_mp #(.DATA_W(64), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(31), .BYPASS(0)) dut_nb (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_nb)
    );

    typedef struct {
        string       tag;
        int          port;
        logic [63:0] data;
        logic        rdy;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_ctl();
        bus.regWriteEnable    = 2'b00;
        bus.reserveEn         = 1'b0;
        bus_nb.regWriteEnable = 2'b00;
        bus_nb.reserveEn      = 1'b0;
    endtask

    task automatic drive_write(input int w, input logic [4:0] addr, input logic [63:0] data);
        bus.writeReg[w*5 +: 5]    = addr;
        bus.writeData[w*64 +: 64] = data;
        bus.regWriteEnable[w]     = 1'b1;
    endtask

    task automatic reserve(input logic [4:0] addr);
        bus.reserveReg = addr;
        bus.reserveEn  = 1'b1;
    endtask

    task automatic expect_read(input string tag, input int port, input logic [4:0] addr,
                               input logic [63:0] data, input logic rdy);
        exp_t e;
        bus.readReg[port*5 +: 5] = addr;
        e.tag  = tag;
        e.port = port;
        e.data = data;
        e.rdy  = rdy;
        exp_q.push_back(e);
    endtask

    task automatic drain_reads();
        exp_t e;
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val({e.tag, "_data"}, bus.readData[e.port*64 +: 64], e.data);
            check_val({e.tag, "_rdy"}, {63'd0, bus.readReady[e.port]}, {63'd0, e.rdy});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clear_ctl();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        bus.readReg = '0;    bus.writeReg = '0;    bus.writeData = '0;    bus.reserveReg = '0;
        bus_nb.readReg = '0; bus_nb.writeReg = '0; bus_nb.writeData = '0; bus_nb.reserveReg = '0;
        clear_ctl();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state on every address
        #1 check_val("rst_anyPending", {63'd0, bus.anyPending}, 64'd0);
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            expect_read("rst_p0", 0, 5'(a), 64'd0, 1'b1);
            expect_read("rst_p1", 1, 5'(a), 64'd0, 1'b1);
            drain_reads();
        end

        // Dual write, then same-address collision
        drive_write(0, 5'd30, 64'd124);
        drive_write(1, 5'd28, 64'd207);
        tick();
        expect_read("wr_r30", 0, 5'd30, 64'd124, 1'b1);
        expect_read("wr_r28", 1, 5'd28, 64'd207, 1'b1);
        drain_reads();
        drive_write(0, 5'd5, 64'hAA);
        drive_write(1, 5'd5, 64'hBB);
        tick();
        expect_read("coll_p0", 0, 5'd5, 64'hBB, 1'b1);
        expect_read("coll_p1", 1, 5'd5, 64'hBB, 1'b1);
        drain_reads();

        // Zero register: no store, no bypass, no reservation
        drive_write(0, 5'd31, 64'hFFFF_FFFF_FFFF_FFF2);
        expect_read("xzr_same", 0, 5'd31, 64'd0, 1'b1);
        drain_reads();
        tick();
        expect_read("xzr_next", 0, 5'd31, 64'd0, 1'b1);
        expect_read("r30_keep", 1, 5'd30, 64'd124, 1'b1);
        drain_reads();
        reserve(5'd31);
        tick();
        #1 check_val("xzr_reserve_any", {63'd0, bus.anyPending}, 64'd0);

        // Bypass on and off
        drive_write(0, 5'd7, 64'h55);
        bus_nb.writeReg[4:0]    = 5'd7;
        bus_nb.writeData[63:0]  = 64'h55;
        bus_nb.regWriteEnable   = 2'b01;
        bus_nb.readReg[4:0]     = 5'd7;
        expect_read("byp_same", 0, 5'd7, 64'h55, 1'b1);
        drain_reads();
        check_val("nobyp_same", bus_nb.readData[63:0], 64'd0);
        check_val("nobyp_same_rdy", {63'd0, bus_nb.readReady[0]}, 64'd1);
        tick();
        #1 check_val("nobyp_next", bus_nb.readData[63:0], 64'h55);
        drive_write(0, 5'd7, 64'h11);
        drive_write(1, 5'd7, 64'h22);
        expect_read("byp_prio", 0, 5'd7, 64'h22, 1'b1);
        drain_reads();
        tick();
        expect_read("byp_prio_store", 1, 5'd7, 64'h22, 1'b1);
        drain_reads();

        // Scoreboard set, clear, and set-beats-clear
        reserve(5'd9);
        tick();
        expect_read("res9", 0, 5'd9, 64'd0, 1'b0);
        drain_reads();
        check_val("res9_any", {63'd0, bus.anyPending}, 64'd1);
        drive_write(0, 5'd9, 64'h99);
        expect_read("res9_byp", 0, 5'd9, 64'h99, 1'b1);
        drain_reads();
        tick();
        expect_read("res9_clr", 0, 5'd9, 64'h99, 1'b1);
        drain_reads();
        check_val("res9_clr_any", {63'd0, bus.anyPending}, 64'd0);
        reserve(5'd9);
        drive_write(1, 5'd9, 64'h123);
        tick();
        expect_read("res9_setwin", 0, 5'd9, 64'h123, 1'b0);
        drain_reads();
        check_val("res9_setwin_any", {63'd0, bus.anyPending}, 64'd1);
        bus_nb.reserveReg    = 5'd9;
        bus_nb.reserveEn     = 1'b1;
        bus_nb.readReg[4:0]  = 5'd9;
        tick();
        #1 check_val("nobyp_res9_rdy", {63'd0, bus_nb.readReady[0]}, 64'd0);

        // Reset mid-sequence drops reservations and overrides a concurrent write
        reserve(5'd3);
        tick();
        reserve(5'd4);
        tick();
        #1 check_val("pre_rst_any", {63'd0, bus.anyPending}, 64'd1);
        reset = 1'b1;
        drive_write(0, 5'd3, 64'hDEAD);
        tick();
        reset = 1'b0;
        #1 check_val("midrst_any", {63'd0, bus.anyPending}, 64'd0);
        expect_read("midrst_r3", 0, 5'd3, 64'd0, 1'b1);
        expect_read("midrst_r9", 1, 5'd9, 64'd0, 1'b1);
        drain_reads();
        expect_read("midrst_r4", 0, 5'd4, 64'd0, 1'b1);
        expect_read("midrst_r30", 1, 5'd30, 64'd0, 1'b1);
        drain_reads();
        drive_write(0, 5'd3, 64'd1);
        tick();
        expect_read("post_rst_r3", 0, 5'd3, 64'd1, 1'b1);
        drain_reads();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
